// File: rtl/uart_cmd_sched.sv
// Command scheduler: runs one parsed UART command (WRITE/READ/NOP/DELAY) against the byte FIFO and transmitter.
// Define SCHED_TIMEOUT_EN to build in the stall watchdog that abandons a stuck WRITE/READ with err=4.
module uart_cmd_sched #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_vld,
    input  logic [7:0]  cmd,
    input  logic [15:0] len,
    input  logic [31:0] sec,
    input  logic        rok,
    input  logic [7:0]  rx_data,
    output logic        fifo_wr,
    output logic [7:0]  fifo_wdata,
    input  logic        fifo_full,
    output logic        fifo_rd,
    input  logic [7:0]  fifo_rdata,
    input  logic        fifo_empty,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        abort,
    output logic        fifo_busy,
    output logic        fifo_done,
    output logic [2:0]  err
);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_NOP   = 8'h03;
    localparam logic [7:0] OP_DELAY = 8'h05;

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_OPCODE   = 3'd1;
    localparam logic [2:0] ERR_COLLIDE  = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_ABORT    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_REQ  = 3'd2,
        RD_CAP  = 3'd3,
        TX_WAIT = 3'd4,
        DELAY   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t            state, state_d;
    logic [15:0]       remain, remain_d;
    logic [31:0]       units, units_d;
    logic [TICK_W-1:0] tick, tick_d;
    logic              hold, hold_d;
    logic              wr_d, rd_d, start_d, busy_d, done_d;
    logic [7:0]        wdata_d, txd_d;
    logic [2:0]        err_d;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  ERR_TIMEOUT = 3'd4;

    logic [IDLE_W-1:0] idle, idle_d;
    logic              stalled_c;

    // Cycles spent waiting without progress; any progress or state change clears the count.
    always_comb begin
        stalled_c = 1'b0;
        case (state)
            WRITE:   stalled_c = !rok;
            RD_REQ:  stalled_c = fifo_empty || tx_busy;
            TX_WAIT: stalled_c = hold || tx_busy;
            default: stalled_c = 1'b0;
        endcase
    end
`else
    // TIMEOUT only matters when the watchdog is built in.
    localparam int unsigned timeout_unused = TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remain     <= '0;
            units      <= '0;
            tick       <= '0;
            hold       <= 1'b0;
            fifo_wr    <= 1'b0;
            fifo_wdata <= '0;
            fifo_rd    <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            fifo_busy  <= 1'b0;
            fifo_done  <= 1'b0;
            err        <= '0;
`ifdef SCHED_TIMEOUT_EN
            idle       <= '0;
`endif
        end else begin
            state      <= state_d;
            remain     <= remain_d;
            units      <= units_d;
            tick       <= tick_d;
            hold       <= hold_d;
            fifo_wr    <= wr_d;
            fifo_wdata <= wdata_d;
            fifo_rd    <= rd_d;
            tx_start   <= start_d;
            tx_data    <= txd_d;
            fifo_busy  <= busy_d;
            fifo_done  <= done_d;
            err        <= err_d;
`ifdef SCHED_TIMEOUT_EN
            idle       <= idle_d;
`endif
        end
    end

    always_comb begin
        state_d  = state;
        remain_d = remain;
        units_d  = units;
        tick_d   = tick;
        hold_d   = 1'b0;
        wr_d     = 1'b0;
        wdata_d  = fifo_wdata;
        rd_d     = 1'b0;
        start_d  = 1'b0;
        txd_d    = tx_data;
        err_d    = err;

        if (cmd_vld && state != IDLE) begin
            err_d = ERR_COLLIDE;
        end

        case (state)
            IDLE: begin
                if (cmd_vld) begin
                    remain_d = len;
                    err_d    = ERR_OK;
                    case (cmd)
                        OP_WRITE: state_d = (len == 16'd0) ? DONE : WRITE;
                        OP_READ:  state_d = (len == 16'd0) ? DONE : RD_REQ;
                        OP_NOP:   state_d = DONE;
                        OP_DELAY: begin
                            tick_d  = TICK_LAST;
                            units_d = sec;
                            state_d = (sec == 32'd0) ? DONE : DELAY;
                        end
                        default: begin
                            state_d = DONE;
                            err_d   = ERR_OPCODE;
                        end
                    endcase
                end
            end
            WRITE: begin
                // Last byte is written one cycle before DONE so fifo_done trails the final strobe.
                if (remain == 16'd0) begin
                    state_d = DONE;
                end else if (rok) begin
                    remain_d = remain - 16'd1;
                    if (fifo_full) begin
                        err_d = ERR_OVERFLOW;
                    end else begin
                        wr_d    = 1'b1;
                        wdata_d = rx_data;
                    end
                end
            end
            RD_REQ: begin
                if (!fifo_empty && !tx_busy) begin
                    rd_d    = 1'b1;
                    state_d = RD_CAP;
                end
            end
            RD_CAP: begin
                start_d = 1'b1;
                txd_d   = fifo_rdata;
                if (remain != 16'd0) begin
                    remain_d = remain - 16'd1;
                end
                hold_d  = 1'b1;
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                // First cycle is skipped so tx_busy has time to rise after tx_start.
                if (!hold && !tx_busy) begin
                    state_d = (remain == 16'd0) ? DONE : RD_REQ;
                end
            end
            DELAY: begin
                if (units == 32'd0) begin
                    state_d = DONE;
                end else if (tick == '0) begin
                    tick_d  = TICK_LAST;
                    units_d = units - 32'd1;
                    if (units == 32'd1) begin
                        state_d = DONE;
                    end
                end else begin
                    tick_d = tick - TICK_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SCHED_TIMEOUT_EN
        idle_d = stalled_c ? idle + IDLE_W'(1) : '0;
        if (stalled_c && idle_d == IDLE_W'(TIMEOUT)) begin
            idle_d  = '0;
            state_d = DONE;
            err_d   = ERR_TIMEOUT;
        end
`endif

        // Abort beats everything in flight and suppresses any strobe about to issue.
        if (abort && state != IDLE && state != DONE) begin
            state_d = DONE;
            err_d   = ERR_ABORT;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            start_d = 1'b0;
            wdata_d = fifo_wdata;
            txd_d   = tx_data;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end
endmodule

// File: tb/tb_uart_cmd_sched.sv
// Directed bench for uart_cmd_sched with a show-ahead FIFO model, a 10-cycle transmitter model and
// expected-data queues for FIFO writes and transmitted bytes. SCHED_TIMEOUT_EN selects the watchdog check.
module tb_uart_cmd_sched;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned TIMEOUT  = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_vld;
    logic [7:0]  cmd;
    logic [15:0] len;
    logic [31:0] sec;
    logic        rok;
    logic [7:0]  rx_data;
    logic        fifo_wr;
    logic [7:0]  fifo_wdata;
    logic        fifo_full;
    logic        fifo_rd;
    logic [7:0]  fifo_rdata;
    logic        fifo_empty;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        abort;
    logic        fifo_busy;
    logic        fifo_done;
    logic [2:0]  err;

    uart_cmd_sched #(.TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd(cmd), .len(len), .sec(sec),
        .rok(rok), .rx_data(rx_data), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .fifo_full(fifo_full), .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .abort(abort), .fifo_busy(fifo_busy), .fifo_done(fifo_done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    int done_cnt = 0;
    int done_at = -1;
    int wr_seen = 0;
    int tx_seen = 0;
    int rd_at = -1;
    int busy_left = 0;
    logic [7:0] wr_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] fq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: advance FIFO/transmitter models, then check strobes against the scoreboard.
    task automatic cyc();
        logic rd_p, ts_p;
        rd_p = fifo_rd;
        ts_p = tx_start;
        @(posedge clk);
        #1;
        cyc_n++;
        if (rd_p === 1'b1 && fq.size() > 0) fq.delete(0);
        fifo_empty = (fq.size() == 0);
        fifo_rdata = fifo_empty ? 8'h00 : fq[0];
        if (ts_p === 1'b1) begin
            tx_busy   = 1'b1;
            busy_left = 10;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
        if (fifo_done === 1'b1) begin
            done_cnt++;
            done_at = cyc_n;
        end
        if (fifo_wr === 1'b1) begin
            wr_seen++;
            if (wr_q.size() == 0) chk("wr_unexpected", 32'(fifo_wr), 32'd0);
            else chk("wr_data", 32'(fifo_wdata), 32'(wr_q.pop_front()));
        end
        if (fifo_rd === 1'b1) begin
            chk("rd_while_busy", 32'(tx_busy), 32'd0);
            if (rd_at >= 0) begin
                total++;
                assert (cyc_n - rd_at >= 3) else begin
                    bad++;
                    $error("FAIL rd_spacing: observed=%0d expected>=3", cyc_n - rd_at);
                end
            end
            rd_at = cyc_n;
        end
        if (tx_start === 1'b1) begin
            tx_seen++;
            chk("tx_while_busy", 32'(tx_busy), 32'd0);
            chk("tx_latency", 32'(cyc_n), 32'(rd_at + 1));
            if (tx_q.size() == 0) chk("tx_unexpected", 32'(tx_start), 32'd0);
            else chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [15:0] l, input logic [31:0] s);
        cmd     = c;
        len     = l;
        sec     = s;
        cmd_vld = 1'b1;
        cyc();
        cmd_vld = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic full);
        rx_data   = b;
        rok       = 1'b1;
        fifo_full = full;
        if (!full) wr_q.push_back(b);
        cyc();
        rok       = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int n);
        n = 0;
        while (fifo_done !== 1'b1 && n < max) begin
            cyc();
            n++;
        end
        chk(tag, 32'(fifo_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, t0, d0, w0, x0;
        logic busy_ok;

        rst_n = 1'b0; cmd_vld = 1'b0; cmd = '0; len = '0; sec = '0; rok = 1'b0; rx_data = '0;
        fifo_full = 1'b0; fifo_rdata = '0; fifo_empty = 1'b1; tx_busy = 1'b0; abort = 1'b0;
        cyc();
        cyc();
        chk("rst_busy", 32'(fifo_busy), 32'd0);
        chk("rst_done", 32'(fifo_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_strobes", 32'({fifo_wr, fifo_rd, tx_start}), 32'd0);
        rst_n = 1'b1;
        cyc();

        // NOP and bad opcode complete the cycle after acceptance
        send(8'h03, 16'd0, 32'd0);
        chk("nop_done", 32'(fifo_done), 32'd1);
        chk("nop_busy", 32'(fifo_busy), 32'd1);
        chk("nop_err", 32'(err), 32'd0);
        cyc();
        chk("nop_idle", 32'({fifo_busy, fifo_done}), 32'd0);
        send(8'h07, 16'd0, 32'd0);
        chk("badop_done", 32'(fifo_done), 32'd1);
        chk("badop_err", 32'(err), 32'd1);
        cyc();
        chk("badop_err_sticky", 32'(err), 32'd1);

        // WRITE three bytes
        w0 = wr_seen;
        send(8'h01, 16'd3, 32'd0);
        chk("wr_busy", 32'(fifo_busy), 32'd1);
        chk("wr_err_cleared", 32'(err), 32'd0);
        rx_byte(8'hA1, 1'b0);
        chk("wr_lat0", 32'(fifo_wr), 32'd1);
        cyc();
        rx_byte(8'hB2, 1'b0);
        chk("wr_lat1", 32'(fifo_wr), 32'd1);
        cyc();
        cyc();
        rx_byte(8'hC3, 1'b0);
        chk("wr_lat2", 32'(fifo_wr), 32'd1);
        chk("wr_done_early", 32'(fifo_done), 32'd0);
        cyc();
        chk("wr_done", 32'(fifo_done), 32'd1);
        chk("wr_err", 32'(err), 32'd0);
        cyc();
        chk("wr_idle", 32'(fifo_busy), 32'd0);
        chk("wr_count", 32'(wr_seen - w0), 32'd3);

        // Overflow: second byte dropped
        w0 = wr_seen;
        send(8'h01, 16'd2, 32'd0);
        rx_byte(8'h55, 1'b0);
        rx_byte(8'h66, 1'b1);
        chk("ovf_no_wr", 32'(fifo_wr), 32'd0);
        cyc();
        chk("ovf_done", 32'(fifo_done), 32'd1);
        chk("ovf_err", 32'(err), 32'd3);
        chk("ovf_count", 32'(wr_seen - w0), 32'd1);
        cyc();

        // READ two preloaded bytes through the busy transmitter
        fq = '{8'h11, 8'h22};
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        fifo_empty = 1'b0;
        fifo_rdata = 8'h11;
        rd_at = -1;
        x0 = tx_seen;
        send(8'h02, 16'd2, 32'd0);
        wait_done("read_done", 100, n);
        chk("read_err", 32'(err), 32'd0);
        chk("read_tx_count", 32'(tx_seen - x0), 32'd2);
        chk("read_fifo_drained", 32'(fq.size()), 32'd0);
        cyc();
        n = 0;
        while (tx_busy === 1'b1 && n < 20) begin cyc(); n++; end

        // DELAY 3 units of 4 cycles
        send(8'h05, 16'd0, 32'd3);
        n = 1;
        busy_ok = 1'b1;
        while (fifo_done !== 1'b1 && n < 40) begin
            if (fifo_busy !== 1'b1) busy_ok = 1'b0;
            cyc();
            n++;
        end
        chk("delay_done", 32'(fifo_done), 32'd1);
        chk("delay_busy", 32'(busy_ok), 32'd1);
        total++;
        assert (n >= 11 && n <= 13) else begin
            bad++;
            $error("FAIL delay_latency: observed=%0d expected=12+-1", n);
        end
        cyc();

        // Collision during DELAY: ignored, err=2, delay still runs to term
        w0 = wr_seen;
        t0 = cyc_n;
        send(8'h05, 16'd0, 32'd2);
        cyc();
        send(8'h01, 16'd5, 32'd0);
        chk("coll_err", 32'(err), 32'd2);
        chk("coll_busy", 32'(fifo_busy), 32'd1);
        wait_done("coll_done", 20, n);
        total++;
        assert (done_at - t0 >= 7 && done_at - t0 <= 9) else begin
            bad++;
            $error("FAIL coll_latency: observed=%0d expected=8+-1", done_at - t0);
        end
        chk("coll_err_final", 32'(err), 32'd2);
        chk("coll_no_write", 32'(wr_seen - w0), 32'd0);
        cyc();
        chk("coll_idle", 32'(fifo_busy), 32'd0);

        // Abort mid-READ while the first byte is transmitting
        fq = '{8'h33, 8'h44};
        tx_q.push_back(8'h33);
        fifo_empty = 1'b0;
        fifo_rdata = 8'h33;
        rd_at = -1;
        send(8'h02, 16'd2, 32'd0);
        n = 0;
        while (tx_start !== 1'b1 && n < 10) begin cyc(); n++; end
        chk("abort_tx_seen", 32'(tx_start), 32'd1);
        cyc();
        cyc();
        chk("abort_not_done", 32'(fifo_done), 32'd0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_done", 32'(fifo_done), 32'd1);
        chk("abort_err", 32'(err), 32'd5);
        cyc();
        chk("abort_idle", 32'({fifo_busy, fifo_done}), 32'd0);
        n = 0;
        while (tx_busy === 1'b1 && n < 20) begin cyc(); n++; end
        chk("abort_fifo_left", 32'(fq.size()), 32'd1);
        fq.delete();
        fifo_empty = 1'b1;
        fifo_rdata = 8'h00;

        // Zero-length commands and abort in IDLE
        send(8'h02, 16'd0, 32'd0);
        chk("zlen_read_done", 32'(fifo_done), 32'd1);
        chk("zlen_read_err", 32'(err), 32'd0);
        cyc();
        send(8'h05, 16'd0, 32'd0);
        chk("zsec_done", 32'(fifo_done), 32'd1);
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("idle_abort_busy", 32'({fifo_busy, fifo_done}), 32'd0);
        chk("idle_abort_err", 32'(err), 32'd0);

        // Stalled WRITE
        d0 = done_cnt;
        send(8'h01, 16'd1, 32'd0);
`ifdef SCHED_TIMEOUT_EN
        wait_done("timeout_done", 40, n);
        total++;
        assert (n + 1 >= 19 && n + 1 <= 22) else begin
            bad++;
            $error("FAIL timeout_latency: observed=%0d expected=20+-1", n + 1);
        end
        chk("timeout_err", 32'(err), 32'd4);
        cyc();
        send(8'h01, 16'd4, 32'd0);
        d0 = done_cnt;
`else
        for (int i = 0; i < 1000; i++) cyc();
        chk("no_timeout_done", 32'(done_cnt - d0), 32'd0);
`endif

        // Reset mid-WRITE
        chk("busy_before_reset", 32'(fifo_busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_busy", 32'(fifo_busy), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_data", 32'({fifo_wdata, tx_data}), 32'd0);
        chk("mid_rst_strobes", 32'({fifo_wr, fifo_rd, tx_start, fifo_done}), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("post_rst_idle", 32'(fifo_busy), 32'd0);

        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
